// File: rtl/pwm_breathe_multi.sv
// Multi-channel breathing PWM driver: one shared counter, per-channel duty that is
// fixed, triangle-ramped or sawtooth-ramped with evenly spread phase offsets.
module pwm_breathe_multi #(
    parameter int CHANNELS     = 3,
    parameter int WIDTH        = 8,
    parameter int STEP_PERIODS = 4,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [1:0]                   mode,
    input  logic [WIDTH-1:0]             duty_in,
    output logic [CHANNELS-1:0]          nled,
    output logic                         period_start,
    output logic [CHANNELS*WIDTH-1:0]    duty_out
);

    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
    localparam int OFS    = (2 ** (WIDTH + 1)) / CHANNELS;
    localparam logic [WIDTH-1:0]    CNT_MAX   = {WIDTH{1'b1}};
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [CHANNELS-1:0] NLED_OFF  = ACTIVE_LOW ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

    logic [WIDTH-1:0]                cnt_q, cnt_d;
    logic [STEP_W-1:0]               step_q, step_d;
    logic [WIDTH:0]                  phase_q, phase_d;
    logic [CHANNELS-1:0][WIDTH-1:0]  duty_q, duty_d;
    logic [CHANNELS-1:0]             nled_q, nled_d;
    logic                            period_start_q, period_start_d;
    logic                            at_max_s;
    logic [CHANNELS-1:0]             lit_s;

    // Duty source for one channel given its own phase; upper phase half folds the triangle down.
    function automatic logic [WIDTH-1:0] duty_src(input logic [1:0] mode_v,
                                                  input logic [WIDTH-1:0] fixed_v,
                                                  input logic [WIDTH:0] p_v);
        logic [WIDTH-1:0] res;
        case (mode_v)
            2'd0:    res = {WIDTH{1'b0}};
            2'd1:    res = fixed_v;
            2'd2:    res = p_v[WIDTH] ? ~p_v[WIDTH-1:0] : p_v[WIDTH-1:0];
            2'd3:    res = p_v[WIDTH-1:0];
            default: res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Next-state: counter, ramp step/phase, per-period duty load and lit decision.
    always_comb begin
        cnt_d          = cnt_q + WIDTH'(1);
        at_max_s       = (cnt_q == CNT_MAX);
        step_d         = step_q;
        phase_d        = phase_q;
        duty_d         = duty_q;
        period_start_d = at_max_s;
        if (at_max_s) begin
            if (step_q == STEP_LAST) begin
                step_d  = {STEP_W{1'b0}};
                phase_d = phase_q + (WIDTH + 1)'(1);
            end else begin
                step_d  = step_q + STEP_W'(1);
            end
            // Duty uses the pre-increment phase so every channel steps on the same edge.
            for (int k = 0; k < CHANNELS; k++) begin
                duty_d[k] = duty_src(mode, duty_in, phase_q + (WIDTH + 1)'(k * OFS));
            end
        end else begin
            duty_d = duty_q;
        end
        for (int k = 0; k < CHANNELS; k++) begin
            lit_s[k] = (cnt_q < duty_q[k]);
        end
        nled_d = ACTIVE_LOW ? ~lit_s : lit_s;
    end

    // State registers; reset and disable both clear everything to the idle state.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            cnt_q          <= {WIDTH{1'b0}};
            step_q         <= {STEP_W{1'b0}};
            phase_q        <= {(WIDTH + 1){1'b0}};
            duty_q         <= {(CHANNELS * WIDTH){1'b0}};
            nled_q         <= NLED_OFF;
            period_start_q <= 1'b0;
        end else begin
            cnt_q          <= cnt_d;
            step_q         <= step_d;
            phase_q        <= phase_d;
            duty_q         <= duty_d;
            nled_q         <= nled_d;
            period_start_q <= period_start_d;
        end
    end

    assign nled         = nled_q;
    assign period_start = period_start_q;
    assign duty_out     = duty_q;

endmodule

// File: tb/tb_pwm_breathe_multi.sv
// Self-checking bench for pwm_breathe_multi (WIDTH=4, CHANNELS=2, STEP_PERIODS=2, active-low).
module tb_pwm_breathe_multi;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] duty_in;
    logic [1:0] nled;
    logic       period_start;
    logic [7:0] duty_out;

    int total;
    int bad;
    int m;
    logic [3:0] md [2];

    typedef struct {
        logic [3:0] duty;
        int         exp_low;
        int         exp_high;
    } fix_vec_t;

    typedef struct {
        int b;
        int d0;
        int d1;
    } tri_pt_t;

    fix_vec_t vecs [5];
    tri_pt_t  tri_pts [8];

    pwm_breathe_multi #(
        .CHANNELS(2),
        .WIDTH(4),
        .STEP_PERIODS(2),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .mode(mode),
        .duty_in(duty_in),
        .nled(nled),
        .period_start(period_start),
        .duty_out(duty_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference duty at boundary b (1-based since release): ramp position is (b-1)/2.
    function automatic logic [3:0] model_duty(input logic [1:0] md_mode, input logic [3:0] din,
                                              input int b, input int k);
        int ph;
        ph = ((b - 1) / 2 + k * 16) % 32;
        case (md_mode)
            2'd0:    return 4'd0;
            2'd1:    return din;
            2'd2:    return (ph < 16) ? 4'(ph) : 4'(31 - ph);
            2'd3:    return 4'(ph % 16);
            default: return 4'd0;
        endcase
    endfunction

    // One clock: advance the model with the inputs held across the edge, then compare.
    task automatic tick();
        logic [1:0] exp_nled;
        int j;
        @(posedge clk);
        if (rst || !en) begin
            m = 0;
            md[0] = 4'd0;
            md[1] = 4'd0;
        end else begin
            m++;
            if (m % 16 == 0) begin
                for (int k = 0; k < 2; k++) md[k] = model_duty(mode, duty_in, m / 16, k);
            end
        end
        #1;
        j = m % 16;
        for (int k = 0; k < 2; k++) exp_nled[k] = ~((j != 0) && (j <= int'(md[k])));
        check("nled", int'(nled), int'(exp_nled));
        check("period_start", int'(period_start), (m > 0 && j == 0) ? 1 : 0);
        check("duty_out", int'(duty_out), int'({md[1], md[0]}));
    endtask

    task automatic to_boundary();
        for (int i = 0; i < 17; i++) begin
            tick();
            if (m % 16 == 0) break;
        end
    endtask

    task automatic measure_first_ps(input string name);
        int c;
        c = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            c++;
            if (period_start) break;
        end
        check(name, c, 16);
    endtask

    task automatic mid_ramp_kill(input bit use_rst);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 2'd2;
        for (int i = 0; i < 400 && m != 18 * 16 + 5; i++) tick();
        if (use_rst) rst = 1'b1;
        else en = 1'b0;
        tick();
        check(use_rst ? "kill_rst_nled" : "kill_en_nled", int'(nled), 3);
        check(use_rst ? "kill_rst_duty" : "kill_en_duty", int'(duty_out), 0);
        rst = 1'b0;
        en  = 1'b1;
        measure_first_ps(use_rst ? "kill_rst_first_ps" : "kill_en_first_ps");
        check("restart_ch0", int'(duty_out[3:0]), 0);
        check("restart_ch1", int'(duty_out[7:4]), 15);
    endtask

    initial begin
        int lo, hi, edges;
        logic [1:0] prev;

        total = 0;
        bad   = 0;
        m     = 0;
        md[0] = 4'd0;
        md[1] = 4'd0;

        vecs[0] = '{4'd5,  5, 11};
        vecs[1] = '{4'd0,  0, 16};
        vecs[2] = '{4'd15, 15, 1};
        vecs[3] = '{4'd10, 10, 6};
        vecs[4] = '{4'd1,  1, 15};

        tri_pts[0] = '{2, 0, 15};
        tri_pts[1] = '{3, 1, 14};
        tri_pts[2] = '{32, 15, 0};
        tri_pts[3] = '{34, 15, 0};
        tri_pts[4] = '{35, 14, 1};
        tri_pts[5] = '{64, 0, 15};
        tri_pts[6] = '{66, 0, 15};
        tri_pts[7] = '{67, 1, 14};

        // Reset held in triangle mode.
        rst     = 1'b1;
        en      = 1'b1;
        mode    = 2'd2;
        duty_in = 4'd0;
        repeat (3) tick();
        check("rst_nled", int'(nled), 3);
        check("rst_duty", int'(duty_out), 0);
        check("rst_ps", int'(period_start), 0);
        rst = 1'b0;
        measure_first_ps("first_ps_delay");

        // Fixed-duty table.
        mode = 2'd1;
        for (int v = 0; v < 5; v++) begin
            duty_in = vecs[v].duty;
            to_boundary();
            lo = 0;
            hi = 0;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (nled == 2'b00) lo++;
                if (nled == 2'b11) hi++;
            end
            check("fixed_low", lo, vecs[v].exp_low);
            check("fixed_high", hi, vecs[v].exp_high);
        end

        // Mid-period duty change: current period keeps 5, next gets 10.
        duty_in = 4'd5;
        to_boundary();
        to_boundary();
        for (int p = 0; p < 2; p++) begin
            lo = 0;
            edges = 0;
            prev = nled;
            for (int i = 0; i < 16; i++) begin
                tick();
                if (m % 16 == 7) duty_in = 4'd10;
                if (nled == 2'b00) lo++;
                if (nled != prev) edges++;
                prev = nled;
            end
            check(p == 0 ? "midchg_cur_low" : "midchg_next_low", lo, p == 0 ? 5 : 10);
            check("midchg_edges", edges, 2);
        end

        // Triangle from a fresh start, with spot checks on the ramp shape.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mode = 2'd2;
        for (int i = 0; i < 1100; i++) begin
            tick();
            for (int t = 0; t < 8; t++) begin
                if (m == tri_pts[t].b * 16) begin
                    check("tri_ch0", int'(duty_out[3:0]), tri_pts[t].d0);
                    check("tri_ch1", int'(duty_out[7:4]), tri_pts[t].d1);
                end
            end
        end

        // Sawtooth: channel 1 sits a full ramp behind, so it matches channel 0.
        mode = 2'd3;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (m % 64 == 0) check("saw_ch_equal", int'(duty_out[7:4]), int'(duty_out[3:0]));
        end

        mid_ramp_kill(1'b1);
        mid_ramp_kill(1'b0);

        // Randomised inputs against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) duty_in = 4'($urandom_range(0, 15));
            en  = ($urandom_range(0, 199) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
